sprite_rom_arbiter: RTL and testbench
=====================================

SPRITE_ROM_ARBITER -- requirements
Module: sprite_rom_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of sprite renderers sharing one sprite ROM.
REQ-002 Parameter ID_W, default 2: sprite-select width; ROM holds 2**ID_W sprites of 16 rows.
REQ-003 Parameter DATA_W, default 16: ROM row width in bits.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 reset  input  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
REQ-006 req  input  NUM_REQ  per-requester fetch request, level; held high until that requester's ack.
REQ-007 sprite_id  input  NUM_REQ*ID_W  requester i sprite select at bits [i*ID_W +: ID_W].
REQ-008 row  input  NUM_REQ*4  requester i row (ycount) at bits [i*4 +: 4].
REQ-009 rom_addr  output  ID_W+4  registered shared ROM address = {sprite_id, row} of granted requester.
REQ-010 rom_bits  input  DATA_W  combinational ROM data for rom_addr, valid same cycle.
REQ-011 ack  output  NUM_REQ  registered one-hot, single-cycle completion strobe.
REQ-012 rd_data  output  DATA_W  registered row data; valid only in the cycle ack is nonzero.
REQ-013 busy  output  1  high while state is FETCH.

Function
REQ-014 States SHALL be IDLE and FETCH only; any other encoding SHALL return to IDLE next cycle.
REQ-015 In IDLE with at least one eligible request at edge N: latch grant index g, load rom_addr from requester g, enter FETCH.
REQ-016 In FETCH: capture rom_bits into rd_data, set ack[g]=1 for one cycle, return to IDLE; ack and rd_data visible in cycle N+2.
REQ-017 Request-to-ack latency SHALL be exactly 2 cycles when uncontended; one grant per 2 cycles maximum throughput.
REQ-018 req[i] SHALL be ineligible in the cycle ack[i] is high (requester drops req the cycle after ack).
REQ-019 Arbitration SHALL be round-robin: search starts at pointer rr, wraps modulo NUM_REQ, first eligible index wins.
REQ-020 After each grant rr SHALL become (g+1) mod NUM_REQ; rr unchanged when no grant.
REQ-021 Simultaneous requests SHALL be served in round-robin order; no requester waits more than NUM_REQ-1 grants.
REQ-022 req/sprite_id/row SHALL be sampled only at grant; later changes do not affect an in-flight fetch.
REQ-023 req dropped after grant: the fetch SHALL still complete and pulse ack; req dropped before grant: no effect.
REQ-024 In IDLE with no eligible request: outputs hold, ack=0, rom_addr holds last value.
REQ-025 ack SHALL never have more than one bit set; ack=0 in every cycle not following FETCH.

Reset
REQ-026 While reset=0 at a clk edge: state=IDLE, rr=0, ack=0, rd_data=0, rom_addr=0, busy=0.
REQ-027 Reset asserted during FETCH SHALL abort the fetch; no ack SHALL be issued for it after reset release.
REQ-028 First grant after release SHALL be possible at the first edge with reset=1.

Structure
REQ-029 Shared package sprite_pkg SHALL hold ROW_W=4, default ID_W, default DATA_W and the IDLE/FETCH state encoding.
REQ-030 Round-robin selection SHALL be a sub-module rr_priority_picker (combinational: req vector, rr pointer in; one-hot grant, index, valid out).
REQ-031 Block SHALL contain no multi-cycle combinational paths from rom_bits to any output other than through rd_data.

Verification
REQ-032 Single req[1], sprite_id=2, row=5 at cycle 0 -> rom_addr=0x25 cycle 1, ack=0b0010 and rd_data=ROM[0x25] cycle 2.
REQ-033 req=0b1111 held, rr=0 -> acks in order 0,1,2,3,0 at cycles 2,4,6,8,10; each requester drops req after its ack.
REQ-034 req[3] and req[0] together with rr=3 -> ack[3] first, then ack[0]; rr ends at 1.
REQ-035 req[2] changes row 3->9 in cycle after grant -> rd_data=ROM[{id,3}], not row 9.
REQ-036 reset=0 asserted in FETCH cycle -> no ack ever appears, all outputs 0, next request acked 2 cycles after release.
REQ-037 req[0] held high in ack cycle with no drop bug injected -> no duplicate grant that cycle; idle bus keeps ack=0.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared constants and FSM encoding for the sprite ROM arbiter.
package sprite_pkg;

  localparam int ROW_W      = 4;
  localparam int DEF_ID_W   = 2;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01
  } state_e;

endpackage

// File: rtl/sprite_rom_arbiter_picker.sv
// Round-robin priority picker: first set request at or after the rr pointer, wrapping.
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  int pos;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    grant = '0;
    pos   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos = (int'(rr) + k) % NUM_REQ;
      if (!valid && req[IDX_W'(pos)]) begin
        valid = 1'b1;
        idx   = IDX_W'(pos);
      end
    end
    if (valid) grant[idx] = 1'b1;
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Shares one sprite ROM between NUM_REQ renderers: round-robin grant, registered
// address, one-cycle ROM read, registered data plus a one-hot ack strobe.
module sprite_rom_arbiter
  import sprite_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = DEF_ID_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ID_W-1:0]   sprite_id,
  input  logic [NUM_REQ*ROW_W-1:0]  row,
  output logic [ID_W+ROW_W-1:0]     rom_addr,
  input  logic [DATA_W-1:0]         rom_bits,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_e                  state, state_nxt;
  logic [IDX_W-1:0]        rr;
  logic [IDX_W-1:0]        pick_idx;
  logic [NUM_REQ-1:0]      pick_grant;
  logic                    pick_valid;
  logic [NUM_REQ-1:0]      eligible;
  logic [NUM_REQ-1:0]      grant_oh_p0;
  logic [ID_W+ROW_W-1:0]   sel_addr;

  // A requester being acked this cycle has not yet had a chance to drop req.
  assign eligible = req & ~ack;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req   (eligible),
    .rr    (rr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i))
        sel_addr = {sprite_id[i*ID_W +: ID_W], row[i*ROW_W +: ROW_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  if (pick_valid) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_FETCH);
  end

  // p0: grant latches address and owner; p1: ROM data and ack leave together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rr          <= '0;
      rom_addr    <= '0;
      grant_oh_p0 <= '0;
      ack         <= '0;
      rd_data     <= '0;
    end else begin
      ack <= '0;
      if (state == ST_IDLE && pick_valid) begin
        rr          <= (pick_idx == IDX_W'(NUM_REQ-1)) ? '0 : pick_idx + 1'b1;
        rom_addr    <= sel_addr;
        grant_oh_p0 <= pick_grant;
      end
      if (state == ST_FETCH) begin
        rd_data <= rom_bits;
        ack     <= grant_oh_p0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: transaction-level model checked every cycle plus
// directed scenarios with hand-computed literals.
module tb_sprite_rom_arbiter;
  import sprite_pkg::*;

  localparam int N  = 4;
  localparam int IW = 2;
  localparam int DW = 16;
  localparam int AW = IW + ROW_W;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [N-1:0]      req = '0;
  logic [N*IW-1:0]   sprite_id = '0;
  logic [N*ROW_W-1:0] row = '0;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_bits;
  logic [N-1:0]      ack;
  logic [DW-1:0]     rd_data;
  logic              busy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_val(input logic [AW-1:0] a);
    return 16'hA5C3 ^ ({10'd0, a} * 16'h0101);
  endfunction

  assign rom_bits = rom_val(rom_addr);

  sprite_rom_arbiter #(.NUM_REQ(N), .ID_W(IW), .DATA_W(DW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .sprite_id (sprite_id),
    .row       (row),
    .rom_addr  (rom_addr),
    .rom_bits  (rom_bits),
    .ack       (ack),
    .rd_data   (rd_data),
    .busy      (busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // Model: one outstanding fetch at a time; a fetch completes the cycle after grant.
  bit            m_busy = 1'b0;
  int            m_idx = 0;
  int            m_rr = 0;
  logic [AW-1:0] m_addr = '0;
  logic [N-1:0]  m_ack = '0;
  logic [DW-1:0] m_rd = '0;

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_busy = 1'b0; m_rr = 0; m_ack = '0; m_rd = '0; m_addr = '0;
    end else if (m_busy) begin
      m_rd = rom_val(m_addr);
      m_ack = '0;
      m_ack[m_idx] = 1'b1;
      m_busy = 1'b0;
    end else begin
      logic [N-1:0] elig;
      elig = req & ~m_ack;
      m_ack = '0;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (m_rr + k) % N;
        if (elig[i]) begin
          m_idx = i;
          m_addr = {sprite_id[i*IW +: IW], row[i*ROW_W +: ROW_W]};
          m_rr = (i + 1) % N;
          m_busy = 1'b1;
          break;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("rom_addr", 32'(rom_addr), 32'(m_addr));
    chk("ack", 32'(ack), 32'(m_ack));
    chk("busy", 32'(busy), 32'(m_busy));
    chk("ack_onehot", 32'($onehot0(ack)), 32'd1);
    if (m_ack != '0) chk("rd_data", 32'(rd_data), 32'(m_rd));
  end

  task automatic setup(input int i, input logic [IW-1:0] id, input logic [ROW_W-1:0] r);
    sprite_id[i*IW +: IW] = id;
    row[i*ROW_W +: ROW_W] = r;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int order[$];
    int when[$];
    int exp_o[5];
    exp_o = '{0, 1, 2, 3, 0};

    // Reset state
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rd_data", 32'(rd_data), 32'h0);
    reset = 1'b1;

    // Single request, sprite 2 row 5
    setup(1, 2'd2, 4'd5);
    req = 4'b0010;
    @(negedge clk);
    chk("t1_addr", 32'(rom_addr), 32'h25);
    chk("t1_busy", 32'(busy), 32'h1);
    @(negedge clk);
    chk("t1_ack", 32'(ack), 32'b0010);
    chk("t1_rd", 32'(rd_data), 32'h80E6);
    req = '0;
    repeat (3) @(negedge clk);
    chk("t1_idle_ack", 32'(ack), 32'h0);

    // Re-reset so rr=0, then all four request together
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < N; i++) setup(i, IW'(i), ROW_W'(i + 1));
    req = 4'b1111;
    for (int t = 1; t <= 10; t++) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (ack[i]) begin
          order.push_back(i);
          when.push_back(t);
          if (i != 0) req[i] = 1'b0;
        end
      end
    end
    req = '0;
    chk("t2_count", 32'(order.size()), 32'd5);
    for (int k = 0; k < order.size() && k < 5; k++) begin
      chk("t2_order", 32'(order[k]), 32'(exp_o[k]));
      chk("t2_cycle", 32'(when[k]), 32'(2 * (k + 1)));
    end
    @(negedge clk);

    // rr is 1; grant requester 2 alone to move rr to 3
    setup(2, 2'd3, 4'd4);
    req = 4'b0100;
    repeat (2) @(negedge clk);
    chk("t3_pre_ack", 32'(ack), 32'b0100);
    req = '0;
    @(negedge clk);
    setup(3, 2'd1, 4'd7);
    setup(0, 2'd2, 4'd8);
    req = 4'b1001;
    repeat (2) @(negedge clk);
    chk("t3_first", 32'(ack), 32'b1000);
    chk("t3_first_rd", 32'(rd_data), 32'(rom_val(6'h17)));
    req[3] = 1'b0;
    repeat (2) @(negedge clk);
    chk("t3_second", 32'(ack), 32'b0001);
    req = '0;
    @(negedge clk);
    req = 4'b0111;
    repeat (2) @(negedge clk);
    chk("t3_rr_is_1", 32'(ack), 32'b0010);
    req = '0;
    repeat (3) @(negedge clk);

    // Inputs changed after grant must not affect the fetch
    setup(2, 2'd1, 4'd3);
    req = 4'b0100;
    @(negedge clk);
    chk("t4_addr", 32'(rom_addr), 32'h13);
    setup(2, 2'd3, 4'd9);
    @(negedge clk);
    chk("t4_ack", 32'(ack), 32'b0100);
    chk("t4_rd", 32'(rd_data), 32'hB6D0);
    req = '0;
    repeat (2) @(negedge clk);

    // Reset during FETCH aborts the fetch
    setup(1, 2'd2, 4'd6);
    req = 4'b0010;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_rst_ack", 32'(ack), 32'h0);
    chk("t5_rst_addr", 32'(rom_addr), 32'h0);
    chk("t5_rst_rd", 32'(rd_data), 32'h0);
    chk("t5_rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_rel_ack", 32'(ack), 32'h0);
    chk("t5_rel_addr", 32'(rom_addr), 32'h26);
    @(negedge clk);
    chk("t5_rel_ack2", 32'(ack), 32'b0010);
    chk("t5_rel_rd", 32'(rd_data), 32'h83E5);
    req = '0;
    repeat (2) @(negedge clk);

    // req held through its ack cycle: no duplicate grant
    setup(0, 2'd3, 4'd15);
    req = 4'b0001;
    repeat (2) @(negedge clk);
    chk("t6_ack", 32'(ack), 32'b0001);
    chk("t6_rd", 32'(rd_data), 32'h9AFC);
    chk("t6_busy_in_ack", 32'(busy), 32'h0);
    @(negedge clk);
    chk("t6_no_regrant", 32'(busy), 32'h0);
    chk("t6_ack_clear", 32'(ack), 32'h0);
    req = '0;
    repeat (4) @(negedge clk);
    chk("t6_idle_ack", 32'(ack), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
